// File: rtl/mips_pkg.sv
// Shared opcode, state and select encodings for the multi-cycle MIPS controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
    localparam logic [1:0] ALUSRCB_SE   = 2'b10;
    localparam logic [1:0] ALUSRCB_SE2  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_known(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface mips_mc_control_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
    );

endinterface

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control decoder; only FETCH/BRANCH look at mem_ready/zero.
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op
);

    logic pc_write;
    logic pc_write_cond;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUSRCB_B;
        alu_op        = ALU_OP_ADD;
        pc_src        = PCSRC_ALU;
        illegal_op    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = ALUSRCB_SE2;
                illegal_op = ~op_known(opcode);
            end
            S_MEMADR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_SE;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_src        = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
            end
            S_ADDI_WB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        pc_en = pc_write | (pc_write_cond & zero);
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS sequencing controller: state register, next-state logic, reset gating.
// Optional MIPS_CTRL_PERF_EN adds retired-instruction and stall counters.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MIPS_CTRL_PERF_EN
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt,
`endif
    mips_mc_control_if.master bus
);

    state_t           state_q;
    state_t           state_d;
    logic [OPW-1:0]   op;
    logic             pc_en_raw, mem_read_raw, mem_write_raw, ir_write_raw;
    logic             reg_write_raw, illegal_raw;

    assign op = bus.opcode;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:    if (bus.mem_ready) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    mips_ctrl_outdec u_outdec (
        .state      (state_q),
        .opcode     (op),
        .zero       (bus.zero),
        .mem_ready  (bus.mem_ready),
        .pc_en      (pc_en_raw),
        .iord       (bus.iord),
        .mem_read   (mem_read_raw),
        .mem_write  (mem_write_raw),
        .ir_write   (ir_write_raw),
        .reg_dst    (bus.reg_dst),
        .mem_to_reg (bus.mem_to_reg),
        .reg_write  (reg_write_raw),
        .alu_src_a  (bus.alu_src_a),
        .alu_src_b  (bus.alu_src_b),
        .alu_op     (bus.alu_op),
        .pc_src     (bus.pc_src),
        .illegal_op (illegal_raw)
    );

    // Strobes are masked combinationally so nothing fires while rst is held,
    // even though FETCH itself would normally assert mem_read.
    assign bus.pc_en      = pc_en_raw     & ~rst;
    assign bus.mem_read   = mem_read_raw  & ~rst;
    assign bus.mem_write  = mem_write_raw & ~rst;
    assign bus.ir_write   = ir_write_raw  & ~rst;
    assign bus.reg_write  = reg_write_raw & ~rst;
    assign bus.illegal_op = illegal_raw   & ~rst;
    assign bus.state      = state_q;

`ifdef MIPS_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (state_q != S_FETCH && state_d == S_FETCH && !illegal_raw)
                retired_cnt <= retired_cnt + 32'd1;
            if (state_q inside {S_FETCH, S_MEMRD, S_MEMWR} && !bus.mem_ready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: per-cycle expected state/controls queued with stimulus.
module tb_mips_mc_control;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_mc_control_if bus ();
`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    mips_mc_control #(.OPW(6)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MIPS_CTRL_PERF_EN
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .bus         (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] obs_o;
    assign obs_o = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                    bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                    bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal_op};

    function automatic logic [15:0] pk(input logic pe, io, mr, mw, iw, rd, m2r, rw, asa,
                                       input logic [1:0] asb, aop, ps, input logic ill);
        return {pe, io, mr, mw, iw, rd, m2r, rw, asa, asb, aop, ps, ill};
    endfunction

    typedef struct packed {
        logic        mr;
        logic        z;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [15:0] o;
    } item_t;

    item_t sb[$];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic push(input logic mr, input logic z, input logic [5:0] op,
                        input state_t st, input logic [15:0] o);
        item_t it;
        it.mr = mr; it.z = z; it.op = op; it.st = st; it.o = o;
        sb.push_back(it);
    endtask

    // Expected per-cycle behaviour of one instruction, written from the state table.
    task automatic queue_instr(input logic [5:0] op, input logic z,
                               input int unsigned fst, input int unsigned mst);
        logic known;
        known = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        for (int unsigned i = 0; i < fst; i++)
            push(1'b0, rb(), rop(), S_FETCH, pk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));
        push(1'b1, rb(), rop(), S_FETCH, pk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0));
        push(rb(), rb(), op, S_DECODE, pk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!known));
        case (op)
            6'b100011: begin
                push(rb(), rb(), op, S_MEMADR, pk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
                for (int unsigned i = 0; i < mst; i++)
                    push(1'b0, rb(), rop(), S_MEMRD, pk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
                push(1'b1, rb(), rop(), S_MEMRD, pk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
                push(rb(), rb(), rop(), S_MEMWB, pk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0));
            end
            6'b101011: begin
                push(rb(), rb(), op, S_MEMADR, pk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
                for (int unsigned i = 0; i < mst; i++)
                    push(1'b0, rb(), rop(), S_MEMWR, pk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
                push(1'b1, rb(), rop(), S_MEMWR, pk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
            end
            6'b000000: begin
                push(rb(), rb(), rop(), S_RTYPE_EX, pk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0));
                push(rb(), rb(), rop(), S_RTYPE_WB, pk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0));
            end
            6'b000100:
                push(rb(), z, rop(), S_BRANCH, pk(z,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0));
            6'b001000: begin
                push(rb(), rb(), rop(), S_ADDI_EX, pk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
                push(rb(), rb(), rop(), S_ADDI_WB, pk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0));
            end
            6'b000010:
                push(rb(), rb(), rop(), S_JUMP, pk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0));
            default: ;
        endcase
    endtask

    task automatic run_queue();
        item_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.mem_ready = it.mr;
            bus.zero      = it.z;
            bus.opcode    = it.op;
            @(negedge clk);
            check_eq($sformatf("state@%0d", cyc), 32'(bus.state), 32'(it.st));
            check_eq($sformatf("outs@%0d", cyc), 32'(obs_o), 32'(it.o));
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b1;
        bus.opcode    = 6'b000010;
        #2;
        check_eq("reset_state", 32'(bus.state), 32'(S_FETCH));
        check_eq("reset_outs", 32'(obs_o), 32'(pk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // lw abandoned by an asynchronous reset while waiting in MEMRD
        push(1'b1, 1'b0, 6'b100011, S_FETCH,  pk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0));
        push(1'b0, 1'b0, 6'b100011, S_DECODE, pk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0));
        push(1'b0, 1'b0, 6'b100011, S_MEMADR, pk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
        run_queue();
        bus.mem_ready = 1'b0;
        #2;
        check_eq("pre_rst_memrd", 32'(bus.state), 32'(S_MEMRD));
        rst = 1'b1;
        #1;
        check_eq("async_rst_state", 32'(bus.state), 32'(S_FETCH));
        check_eq("async_rst_outs", 32'(obs_o), 32'(pk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_state", 32'(bus.state), 32'(S_FETCH));
        check_eq("post_rst_outs", 32'(obs_o), 32'(pk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)));
        @(posedge clk);
        #1;

        queue_instr(OP_LW,   1'b0, 0, 0);
        queue_instr(OP_SW,   1'b0, 0, 3);
        queue_instr(OP_BEQ,  1'b1, 0, 0);
        queue_instr(OP_BEQ,  1'b0, 0, 0);
        queue_instr(6'b111111, 1'b0, 0, 0);
        queue_instr(OP_RTYPE, 1'b0, 0, 0);
        queue_instr(OP_ADDI, 1'b0, 0, 0);
        queue_instr(OP_J,    1'b0, 0, 0);
        queue_instr(OP_LW,   1'b0, 2, 1);
        queue_instr(OP_SW,   1'b1, 1, 0);
        run_queue();

`ifdef MIPS_CTRL_PERF_EN
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        queue_instr(OP_RTYPE, 1'b0, 0, 0);
        queue_instr(OP_ADDI, 1'b0, 0, 0);
        queue_instr(OP_J,    1'b0, 0, 0);
        queue_instr(6'b111111, 1'b0, 0, 0);
        run_queue();
        check_eq("retired_cnt", retired_cnt, 32'd3);
        check_eq("stall_cnt", stall_cnt, 32'd0);
        queue_instr(OP_SW, 1'b0, 2, 3);
        run_queue();
        check_eq("retired_cnt2", retired_cnt, 32'd4);
        check_eq("stall_cnt2", stall_cnt, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
